systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17, operand width (signed).
REQ-002 SHALL have parameter ACC_WIDTH, default DATA_WIDTH*4+1, accumulator width (signed).
REQ-003 SHALL have parameter K_MAX, default 8, maximum inner dimension per tile.
REQ-004 SHALL have parameter PE_LAT, default 2, extra drain cycles covering PE pipeline depth.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  start a tile; sampled in IDLE only.
REQ-008 k_len_i  in  $clog2(K_MAX+1)  tile inner dimension; sampled with start_i.
REQ-009 in_valid_i / in_ready_o  in/out  1 each  operand beat handshake.
REQ-010 a0_i, a1_i, b0_i, b1_i  in  DATA_WIDTH each  beat k: A[0][k], A[1][k], B[k][0], B[k][1].
REQ-011 data_a_0_o, data_a_1_o, data_b_0_o, data_b_1_o  out  DATA_WIDTH each  skewed streams to array inputs.
REQ-012 acc_en_o  out  1  array accumulate enable.
REQ-013 acc_0_i..acc_3_i  in  ACC_WIDTH each  array accumulator outputs (C00, C01, C10, C11).
REQ-014 res_valid_o / res_ready_i  out/in  1 each  result handshake.
REQ-015 res_0_o..res_3_o  out  ACC_WIDTH each  tile result C00, C01, C10, C11.
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE, FEED, DRAIN, OUT.
REQ-018 IDLE: in_ready_o=0, acc_en_o=0, data outputs 0; base_n <= acc_n_i every cycle.
REQ-019 IDLE & start_i & k_len_i in 1..K_MAX -> FEED next cycle; latch k_len_i; beat counter <= 0.
REQ-020 IDLE & start_i & k_len_i=0 -> OUT with all results 0; k_len_i>K_MAX treated as K_MAX.
REQ-021 FEED: in_ready_o=1, acc_en_o=1; each accepted beat increments the beat counter; after beat k_len-1 is accepted -> DRAIN.
REQ-022 Beat accepted at edge t: data_a_0_o=a0, data_b_0_o=b0 in cycle t+1; data_a_1_o=a1, data_b_1_o=b1 in cycle t+2.
REQ-023 Cycle without an accepted beat: the corresponding stream slot SHALL be 0 (bubble contributes zero product); acc_en_o stays 1.
REQ-024 DRAIN: in_ready_o=0, acc_en_o=1, new slots 0; lasts 2+PE_LAT cycles, then -> OUT.
REQ-025 OUT entry: res_n_o <= acc_n_i - base_n, modulo 2^ACC_WIDTH; res_valid_o=1; acc_en_o=0.
REQ-026 OUT: results held stable until res_valid_o & res_ready_i, then -> IDLE next cycle.
REQ-027 start_i outside IDLE SHALL be ignored; in_valid_i outside FEED SHALL be ignored.
REQ-028 All outputs SHALL be registered; no combinational path input->output.

Reset
REQ-029 rst SHALL force IDLE in the next cycle from any state, including mid-FEED/DRAIN, discarding the tile.
REQ-030 Reset values: all data outputs 0, acc_en_o=0, in_ready_o=0, res_valid_o=0, res_n_o=0, busy_o=0, counters 0, skew registers 0.

Structure
REQ-031 Shared package systolic_pkg SHALL hold the state enum, DATA_WIDTH, ACC_WIDTH, K_MAX defaults.
REQ-032 One sub-module skew_reg (one-cycle DATA_WIDTH delay, sync reset to 0) SHALL be instantiated for the a1 and b1 lanes.

Verification
REQ-033 A=[[1,2],[3,4]], B=[[5,6],[7,8]], k=2, beats back-to-back, array attached -> res = 19, 22, 43, 50.
REQ-034 Same tile with in_valid_i low for 3 cycles between beats -> identical results; zeros observed on streams during bubble.
REQ-035 Two tiles back-to-back without array reset (second: A=I, B=[[2,0],[0,3]]) -> second results 2, 0, 0, 3 (base subtraction).
REQ-036 res_ready_i held low 5 cycles -> res_valid_o and res values stable 5 cycles; start_i pulsed meanwhile ignored.
REQ-037 rst asserted during FEED after 1 of 4 beats -> next cycle busy_o=0, all outputs 0; a fresh k=1 tile (1,1,1,1) yields 1, 1, 1, 1.
REQ-038 k_len_i=0 -> res_valid_o within 1 cycle, all results 0, no in_ready_o pulse.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic array feeder.
//   state_t          : feeder FSM states
//   *_DEF localparams: default operand/accumulator width and tile depth
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 17;
  localparam int ACC_WIDTH_DEF  = DATA_WIDTH_DEF*4+1;
  localparam int K_MAX_DEF      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

endpackage

// File: rtl/skew_reg.sv
// One-cycle delay register used to skew the row-1 / column-1 operand lanes.
//   clk, rst : clock, synchronous active-high reset (clears q to 0)
//   d        : lane input
//   q        : lane input delayed by one cycle
module skew_reg #(
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds one K-deep tile of operands into a 2x2 output-stationary systolic
// array with the diagonal skew the array expects, waits for the array pipe
// to drain, then reports the tile result as the accumulator delta since the
// tile started (so the array never needs clearing between tiles).
//   clk, rst                 : clock, synchronous active-high reset
//   start_i, k_len_i         : tile start and inner dimension (IDLE only)
//   in_valid_i / in_ready_o  : operand beat handshake (a0,a1,b0,b1)
//   data_{a,b}_{0,1}_o       : skewed operand streams to the array
//   acc_en_o                 : array accumulate enable
//   acc_{0..3}_i             : array accumulators C00, C01, C10, C11
//   res_valid_o / res_ready_i: result handshake, res_{0..3}_o
//   busy_o                   : feeder not idle
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = DATA_WIDTH*4+1,
  parameter int K_MAX      = K_MAX_DEF,
  parameter int PE_LAT     = 2,
  localparam int KW        = $clog2(K_MAX+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [KW-1:0]         k_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a0_i,
  input  logic [DATA_WIDTH-1:0] a1_i,
  input  logic [DATA_WIDTH-1:0] b0_i,
  input  logic [DATA_WIDTH-1:0] b1_i,
  output logic [DATA_WIDTH-1:0] data_a_0_o,
  output logic [DATA_WIDTH-1:0] data_a_1_o,
  output logic [DATA_WIDTH-1:0] data_b_0_o,
  output logic [DATA_WIDTH-1:0] data_b_1_o,
  output logic                  acc_en_o,
  input  logic [ACC_WIDTH-1:0]  acc_0_i,
  input  logic [ACC_WIDTH-1:0]  acc_1_i,
  input  logic [ACC_WIDTH-1:0]  acc_2_i,
  input  logic [ACC_WIDTH-1:0]  acc_3_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [ACC_WIDTH-1:0]  res_0_o,
  output logic [ACC_WIDTH-1:0]  res_1_o,
  output logic [ACC_WIDTH-1:0]  res_2_o,
  output logic [ACC_WIDTH-1:0]  res_3_o,
  output logic                  busy_o
);

  localparam int DRAIN_LEN = PE_LAT + 2;
  localparam int DW        = $clog2(DRAIN_LEN+1);

  state_t state, state_n;

  logic [KW-1:0]                k_q, beat_cnt, k_eff;
  logic [DW-1:0]                drain_cnt;
  logic [3:0][ACC_WIDTH-1:0]    acc_v, base_q, res_q;
  logic [DATA_WIDTH-1:0]        a1_q, b1_q;
  logic                         accept, last_beat, drain_done;

  assign acc_v = {acc_3_i, acc_2_i, acc_1_i, acc_0_i};
  assign {res_3_o, res_2_o, res_1_o, res_0_o} = res_q;

  // Oversized tiles are clamped rather than rejected.
  assign k_eff      = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
  assign accept     = in_valid_i && in_ready_o;
  assign last_beat  = accept && (beat_cnt == k_q - KW'(1));
  assign drain_done = (drain_cnt == DW'(DRAIN_LEN-1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start_i)     state_n = (k_eff == '0) ? S_OUT : S_FEED;
      S_FEED:  if (last_beat)   state_n = S_DRAIN;
      S_DRAIN: if (drain_done)  state_n = S_OUT;
      S_OUT:   if (res_valid_o && res_ready_i) state_n = S_IDLE;
      default:                  state_n = S_IDLE;
    endcase
  end

  // Control outputs are registered copies of the next-state decode so they
  // line up with the state they describe without a comb path to the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_o  <= 1'b0;
      acc_en_o    <= 1'b0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
      res_q       <= '0;
      base_q      <= '0;
      k_q         <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      data_a_0_o  <= '0;
      data_b_0_o  <= '0;
      a1_q        <= '0;
      b1_q        <= '0;
    end else begin
      in_ready_o <= (state_n == S_FEED);
      acc_en_o   <= (state_n == S_FEED) || (state_n == S_DRAIN);
      busy_o     <= (state_n != S_IDLE);
      // Non-accepted cycles inject zeros so bubbles add nothing to the array.
      data_a_0_o <= accept ? a0_i : '0;
      data_b_0_o <= accept ? b0_i : '0;
      a1_q       <= accept ? a1_i : '0;
      b1_q       <= accept ? b1_i : '0;
      unique case (state)
        S_IDLE: begin
          // Track the free-running array so the tile result is a delta.
          base_q    <= acc_v;
          beat_cnt  <= '0;
          drain_cnt <= '0;
          if (start_i) begin
            k_q <= k_eff;
            if (k_eff == '0) begin
              res_q       <= '0;
              res_valid_o <= 1'b1;
            end
          end
        end
        S_FEED:  if (accept) beat_cnt <= beat_cnt + KW'(1);
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_done) begin
            for (int i = 0; i < 4; i++) res_q[i] <= acc_v[i] - base_q[i];
            res_valid_o <= 1'b1;
          end
        end
        S_OUT:   if (res_ready_i) res_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // Row/column 1 lanes arrive one cycle after lanes 0.
  skew_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skew_a1 (
    .clk(clk), .rst(rst), .d(a1_q), .q(data_a_1_o)
  );
  skew_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skew_b1 (
    .clk(clk), .rst(rst), .d(b1_q), .q(data_b_1_o)
  );

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with an attached behavioural 2x2 output-stationary
// array. Expected tile products are pushed when a tile is driven and popped
// when the feeder presents its result.
module tb_systolic_feeder;
  localparam int DW = 17;
  localparam int AW = DW*4+1;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, acc_en, res_valid, res_ready, busy;
  logic [KW-1:0] k_len;
  logic [DW-1:0] a0, a1, b0, b1, da0, da1, db0, db1;
  logic [AW-1:0] acc [4];
  logic [AW-1:0] res [4];

  int n_cmp = 0, n_bad = 0;
  logic [AW-1:0] exp_q [$];
  int ta0[8], ta1[8], tb0[8], tb1[8];

  always #5 clk = ~clk;

  systolic_feeder dut (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a0_i(a0), .a1_i(a1), .b0_i(b0), .b1_i(b1),
    .data_a_0_o(da0), .data_a_1_o(da1), .data_b_0_o(db0), .data_b_1_o(db1),
    .acc_en_o(acc_en),
    .acc_0_i(acc[0]), .acc_1_i(acc[1]), .acc_2_i(acc[2]), .acc_3_i(acc[3]),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_0_o(res[0]), .res_1_o(res[1]), .res_2_o(res[2]), .res_3_o(res[3]),
    .busy_o(busy)
  );

  // Behavioural array: a flows right, b flows down, PEs accumulate on acc_en.
  logic arr_clr;
  logic [DW-1:0] fa00, fb00, fa10, fb01;

  function automatic logic [AW-1:0] prod(input logic signed [DW-1:0] x, y);
    prod = AW'(x) * AW'(y);
  endfunction

  always_ff @(posedge clk) begin
    if (arr_clr) begin
      fa00 <= '0; fb00 <= '0; fa10 <= '0; fb01 <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      fa00 <= da0; fb00 <= db0; fa10 <= da1; fb01 <= db1;
      if (acc_en) begin
        acc[0] <= acc[0] + prod(da0,  db0);
        acc[1] <= acc[1] + prod(fa00, db1);
        acc[2] <= acc[2] + prod(da1,  fb00);
        acc[3] <= acc[3] + prod(fa10, fb01);
      end
    end
  end

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_beats(input int v0[8], input int v1[8], input int w0[8], input int w1[8]);
    ta0 = v0; ta1 = v1; tb0 = w0; tb1 = w1;
  endtask

  // Drives one tile; gap = idle cycles between beats, hold = cycles res_ready
  // is held low once the result appears (with a start pulse that must be ignored).
  task automatic run_tile(input int k, input int gap, input int hold, input bit bubble_chk);
    int nb, n;
    logic [AW-1:0] e [4];
    nb = (k > 8) ? 8 : k;
    begin
      int c00 = 0, c01 = 0, c10 = 0, c11 = 0;
      for (int i = 0; i < nb; i++) begin
        c00 += ta0[i]*tb0[i]; c01 += ta0[i]*tb1[i];
        c10 += ta1[i]*tb0[i]; c11 += ta1[i]*tb1[i];
      end
      exp_q.push_back(AW'(c00)); exp_q.push_back(AW'(c01));
      exp_q.push_back(AW'(c10)); exp_q.push_back(AW'(c11));
    end
    @(negedge clk); start = 1'b1; k_len = KW'(k);
    @(negedge clk); start = 1'b0;
    if (k == 0) begin
      chk("k0_valid_1cyc", AW'(res_valid), 1);
      chk("k0_no_ready", AW'(in_ready), 0);
    end
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      a0 = DW'(ta0[i]); a1 = DW'(ta1[i]); b0 = DW'(tb0[i]); b1 = DW'(tb1[i]);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk("ready_timeout", AW'(n >= 50), 0);
      @(negedge clk); in_valid = 1'b0;
      if (bubble_chk) begin
        chk("skew_a0", AW'(da0), AW'(ta0[i]));
        chk("skew_b0", AW'(db0), AW'(tb0[i]));
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (bubble_chk && g == 0) begin
          chk("bub_a0_zero", AW'(da0), 0);
          chk("skew_a1", AW'(da1), AW'(ta1[i]));
          chk("skew_b1", AW'(db1), AW'(tb1[i]));
          chk("bub_acc_en", AW'(acc_en), 1);
        end
        if (bubble_chk && g == 1)
          chk("bub_all_zero", AW'({da0, da1, db0, db1}), 0);
      end
    end
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    chk("res_timeout", AW'(n >= 50), 0);
    for (int j = 0; j < 4; j++) e[j] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int j = 0; j < 4; j++) chk($sformatf("res%0d", j), res[j], e[j]);
    chk("out_acc_en", AW'(acc_en), 0);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1); k_len = 4'd1;
      @(negedge clk);
      chk("hold_valid", AW'(res_valid), 1);
      for (int j = 0; j < 4; j++) chk($sformatf("hold_res%0d", j), res[j], e[j]);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    chk("post_valid", AW'(res_valid), 0);
    chk("post_busy", AW'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; arr_clr = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    res_ready = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", AW'(busy), 0);
    chk("rst_ready", AW'(in_ready), 0);
    chk("rst_acc_en", AW'(acc_en), 0);
    chk("rst_valid", AW'(res_valid), 0);
    chk("rst_data", AW'({da0, da1, db0, db1}), 0);
    chk("rst_res0", res[0], 0);
    rst = 1'b0; arr_clr = 1'b0;
    @(negedge clk);

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]] back-to-back, result held 5 cycles
    set_beats('{1,2,0,0,0,0,0,0}, '{3,4,0,0,0,0,0,0},
              '{5,7,0,0,0,0,0,0}, '{6,8,0,0,0,0,0,0});
    run_tile(2, 0, 5, 1'b0);
    // same tile with 3-cycle bubbles between beats
    run_tile(2, 3, 0, 1'b1);
    // A=I, B=diag(2,3) without clearing the array
    set_beats('{1,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0},
              '{2,0,0,0,0,0,0,0}, '{0,3,0,0,0,0,0,0});
    run_tile(2, 0, 0, 1'b0);
    // empty tile
    run_tile(0, 0, 0, 1'b0);
    // oversized k clamps to 8 beats
    set_beats('{1,2,3,4,5,6,7,8}, '{8,7,6,5,4,3,2,1},
              '{1,1,1,1,1,1,1,1}, '{2,0,2,0,2,0,2,0});
    run_tile(15, 1, 0, 1'b0);

    // reset mid-FEED after one of four beats
    @(negedge clk); start = 1'b1; k_len = 4'd4;
    @(negedge clk); start = 1'b0; in_valid = 1'b1;
    a0 = 17'd9; a1 = 17'd9; b0 = 17'd9; b1 = 17'd9;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", AW'(busy), 0);
    chk("mid_rst_ready", AW'(in_ready), 0);
    chk("mid_rst_acc_en", AW'(acc_en), 0);
    chk("mid_rst_data", AW'({da0, da1, db0, db1}), 0);
    chk("mid_rst_valid", AW'(res_valid), 0);
    chk("mid_rst_res", res[0] | res[1] | res[2] | res[3], 0);
    @(negedge clk);
    set_beats('{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0},
              '{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0});
    run_tile(1, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
